// File: rtl/ram_dbus_adapter_pkg.sv
// Shared data-bus types for the RAM adapter: request/response field types,
// grouped request/response structs and the alignment helper.
package ram_dbus_adapter_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [2:0]  msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
    logic  err;
  } dbus_resp_t;

  // Sizes of 8 bytes and above need the whole byte offset to be zero.
  function automatic logic is_aligned(input addr_t addr, input msize_t size);
    logic [2:0] mask;
    case (size)
      3'd0:    mask = 3'b000;
      3'd1:    mask = 3'b001;
      3'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (addr[2:0] & mask) == 3'b000;
  endfunction

endpackage

// File: rtl/ram_dbus_adapter.sv
// Data-bus slave in front of a single-port byte-strobed RAM: issues one request
// at a time, waits the RAM read latency and returns registered read data.
module ram_dbus_adapter
  import ram_dbus_adapter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic [63:0]           req_addr,
  input  logic [2:0]            req_size,
  input  logic [7:0]            req_strobe,
  input  logic [63:0]           req_data,
  output logic                  resp_addr_ok,
  output logic                  resp_data_ok,
  output logic [63:0]           resp_data,
  output logic                  resp_err,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_strobe,
  output logic [63:0]           ram_wdata,
  input  logic [63:0]           ram_rdata
);

  localparam int CNT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  word_t             rdata_q, rdata_d;
  logic              err_q, err_d;

  dbus_req_t         req_s;
  dbus_resp_t        resp_s;
  logic              ram_en_s;
  strobe_t           ram_strobe_s;
  logic              unused_s;

  assign req_s.valid  = req_valid;
  assign req_s.addr   = req_addr;
  assign req_s.size   = req_size;
  assign req_s.strobe = req_strobe;
  assign req_s.data   = req_data;

  // High address bits alias onto the RAM and are intentionally dropped.
  assign unused_s = ^req_addr[63:ADDR_WIDTH+3];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wr_d           = wr_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    resp_s.addr_ok = 1'b0;
    resp_s.data_ok = (state_q == DONE);
    resp_s.data    = rdata_q;
    resp_s.err     = err_q;
    ram_en_s       = 1'b0;
    ram_strobe_s   = 8'h00;
    case (state_q)
      IDLE: begin
        if (req_s.valid && resetn) begin
          resp_s.addr_ok = 1'b1;
          rdata_d        = 64'h0;
          if (is_aligned(req_s.addr, req_s.size)) begin
            ram_en_s     = 1'b1;
            ram_strobe_s = req_s.strobe;
            cnt_d        = CNT_W'(READ_LATENCY);
            wr_d         = |req_s.strobe;
            err_d        = 1'b0;
            state_d      = BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(0)) begin
          rdata_d = wr_q ? 64'h0 : ram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_addr_ok = resp_s.addr_ok;
  assign resp_data_ok = resp_s.data_ok;
  assign resp_data    = resp_s.data;
  assign resp_err     = resp_s.err;
  assign ram_en       = ram_en_s;
  assign ram_strobe   = ram_strobe_s;
  assign ram_addr     = ram_en_s ? req_s.addr[ADDR_WIDTH+2:3] : '0;
  assign ram_wdata    = ram_en_s ? req_s.data : 64'h0;

endmodule

// File: tb/tb_ram_dbus_adapter.sv
// Bench: three adapters (read latency 0, 1, 2), each paired with its own RAM model.
module tb_ram_dbus_adapter;
  import ram_dbus_adapter_pkg::*;

  localparam int AW = 10;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn       [NI];
  logic           req_valid    [NI];
  addr_t          req_addr     [NI];
  msize_t         req_size     [NI];
  strobe_t        req_strobe   [NI];
  word_t          req_data     [NI];
  logic           resp_addr_ok [NI];
  logic           resp_data_ok [NI];
  word_t          resp_data    [NI];
  logic           resp_err     [NI];
  logic           ram_en       [NI];
  logic [AW-1:0]  ram_addr     [NI];
  strobe_t        ram_strobe   [NI];
  word_t          ram_wdata    [NI];
  word_t          ram_rdata    [NI];

  int checks = 0;
  int errors = 0;
  int dok_cnt [NI];

  word_t ref_mem [NI][1<<AW];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    ram_dbus_adapter #(.ADDR_WIDTH(AW), .READ_LATENCY(g)) u_dut (
      .clk(clk), .resetn(resetn[g]), .req_valid(req_valid[g]), .req_addr(req_addr[g]),
      .req_size(req_size[g]), .req_strobe(req_strobe[g]), .req_data(req_data[g]),
      .resp_addr_ok(resp_addr_ok[g]), .resp_data_ok(resp_data_ok[g]),
      .resp_data(resp_data[g]), .resp_err(resp_err[g]), .ram_en(ram_en[g]),
      .ram_addr(ram_addr[g]), .ram_strobe(ram_strobe[g]), .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g])
    );

    // RAM model: output holds the last word read, delayed by g cycles
    word_t         mem [1<<AW];
    logic [AW-1:0] hold_q;
    logic [AW-1:0] rd_idx_s;
    word_t         p0_s, p1_q, p2_q;
    assign rd_idx_s = ram_en[g] ? ram_addr[g] : hold_q;
    assign p0_s     = mem[rd_idx_s];
    always @(posedge clk) begin
      if (ram_en[g]) begin
        hold_q <= ram_addr[g];
        for (int b = 0; b < 8; b++)
          if (ram_strobe[g][b]) mem[ram_addr[g]][b*8 +: 8] <= ram_wdata[g][b*8 +: 8];
      end
      p1_q <= p0_s;
      p2_q <= p1_q;
    end
    assign ram_rdata[g] = (g == 0) ? p0_s : ((g == 1) ? p1_q : p2_q);
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++)
      if (resp_data_ok[k]) dok_cnt[k] <= dok_cnt[k] + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, word = (addr/8) mod 2**AW, misaligned if offset mod size != 0
  task automatic ref_access(input int k, input addr_t a, input msize_t sz, input strobe_t st,
                            input word_t d, output logic e, output word_t rd, output int lat,
                            output int en);
    int bytes;
    int idx;
    bytes = 1 << sz;
    idx   = int'((a / 64'd8) % 64'(1 << AW));
    rd    = 64'h0;
    if ((int'(a % 64'd8) % bytes) != 0) begin
      e = 1'b1; lat = 1; en = 0;
    end else begin
      e = 1'b0; lat = k + 2; en = 1;
      if (st == 8'h00) rd = ref_mem[k][idx];
      else
        for (int b = 0; b < 8; b++)
          if (st[b]) ref_mem[k][idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // Drive one request (called just after a posedge); returns response and timing
  task automatic do_req(input int k, input addr_t a, input msize_t sz, input strobe_t st,
                        input word_t d, input logic keep, input int exp_en,
                        output logic e, output word_t rd, output int lat, output int t);
    int en_cnt;
    logic both;
    req_valid[k] = 1'b1; req_addr[k] = a; req_size[k] = sz;
    req_strobe[k] = st; req_data[k] = d;
    t = -1; lat = -1; e = 1'b0; rd = 64'h0; en_cnt = 0; both = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_en[k]) en_cnt++;
      if (resp_addr_ok[k] && resp_data_ok[k]) both = 1'b1;
      if (resp_addr_ok[k] && t < 0) begin
        t = c;
        if (exp_en != 0) begin
          chk("ram_addr", 64'(ram_addr[k]), 64'((a / 64'd8) % 64'(1 << AW)));
          chk("ram_strobe", 64'(ram_strobe[k]), 64'(st));
          chk("ram_wdata", ram_wdata[k], d);
        end
      end
      if (resp_data_ok[k]) begin
        if (t >= 0) lat = c - t;
        e = resp_err[k]; rd = resp_data[k];
        break;
      end
    end
    chk("ram_en_pulses", 64'(en_cnt), 64'(exp_en));
    chk("addr_ok_with_data_ok", 64'(both), 64'd0);
    @(posedge clk); #1;
    if (!keep) req_valid[k] = 1'b0;
  endtask

  task automatic run_ref(input int k, input addr_t a, input msize_t sz, input strobe_t st,
                         input word_t d, input logic keep, output int t);
    logic  ee, ae;
    word_t erd, ard;
    int    elat, alat, een;
    ref_access(k, a, sz, st, d, ee, erd, elat, een);
    do_req(k, a, sz, st, d, keep, een, ae, ard, alat, t);
    chk("resp_err", 64'(ae), 64'(ee));
    chk("resp_data", ard, erd);
    chk("latency", 64'(alat), 64'(elat));
  endtask

  typedef struct {
    addr_t a; msize_t sz; strobe_t st; word_t d;
    logic e; word_t rd; int lat; int en;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic  ae, de;
    word_t ard, drd;
    int    alat, t, dlat, den, dok0, pulses;

    vt[0]  = '{64'h18, 3'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0, 3, 1};
    vt[1]  = '{64'h18, 3'd3, 8'h00, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 3, 1};
    vt[2]  = '{64'h0, 3'd3, 8'h0F, 64'h11223344_55667788, 1'b0, 64'h0, 3, 1};
    vt[3]  = '{64'h0, 3'd3, 8'h00, 64'h0, 1'b0, 64'h00000000_55667788, 3, 1};
    vt[4]  = '{64'h6, 3'd2, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 64'h0, 1, 0};
    vt[5]  = '{64'h0, 3'd3, 8'h00, 64'h0, 1'b0, 64'h00000000_55667788, 3, 1};
    vt[6]  = '{64'h4, 3'd3, 8'h00, 64'h0, 1'b1, 64'h0, 1, 0};
    vt[7]  = '{64'h1A, 3'd1, 8'h00, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 3, 1};
    vt[8]  = '{64'hFFFF0000_00002018, 3'd3, 8'h00, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 3, 1};
    vt[9]  = '{64'h7, 3'd0, 8'h80, 64'hAA000000_00000000, 1'b0, 64'h0, 3, 1};
    vt[10] = '{64'h0, 3'd3, 8'h00, 64'h0, 1'b0, 64'hAA000000_55667788, 3, 1};

    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b0; req_valid[k] = 1'b1; req_addr[k] = 64'h8; req_size[k] = 3'd3;
      req_strobe[k] = 8'hFF; req_data[k] = 64'h12345678_9ABCDEF0;
    end

    // Reset held for three cycles with a request pending
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("reset_ctrl", 64'({resp_addr_ok[k], resp_data_ok[k], resp_err[k], ram_en[k],
                               ram_strobe[k], ram_addr[k]}), 64'd0);
        chk("reset_data", resp_data[k] | ram_wdata[k], 64'd0);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b1; req_valid[k] = 1'b0;
    end

    // Zero the words the rest of the test uses
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 32; w++)
        run_ref(k, 64'(w * 8), 3'd3, 8'hFF, 64'h0, 1'b0, t);

    // Directed table on the latency-1 instance
    for (int i = 0; i < 11; i++) begin
      ref_access(1, vt[i].a, vt[i].sz, vt[i].st, vt[i].d, de, drd, dlat, den);
      do_req(1, vt[i].a, vt[i].sz, vt[i].st, vt[i].d, 1'b0, vt[i].en, ae, ard, alat, t);
      chk($sformatf("vec%0d_err", i), 64'(ae), 64'(vt[i].e));
      chk($sformatf("vec%0d_data", i), ard, vt[i].rd);
      chk($sformatf("vec%0d_lat", i), 64'(alat), 64'(vt[i].lat));
    end

    // Back-to-back reads with req_valid held high
    dok0 = dok_cnt[1];
    for (int i = 0; i < 4; i++) begin
      run_ref(1, 64'(i * 8), 3'd3, 8'h00, 64'h0, (i < 3), t);
      if (i > 0) chk("b2b_issue_gap", 64'(t), 64'd0);
    end
    repeat (4) @(posedge clk);
    #1;
    pulses = dok_cnt[1] - dok0;
    chk("b2b_pulses", 64'(pulses), 64'd4);

    // Reset during BUSY on the latency-2 instance drops the response
    req_valid[2] = 1'b1; req_addr[2] = 64'h18; req_size[2] = 3'd3;
    req_strobe[2] = 8'h00; req_data[2] = 64'h0;
    @(negedge clk);
    chk("midbusy_addr_ok", 64'(resp_addr_ok[2]), 64'd1);
    dok0 = dok_cnt[2];
    @(posedge clk); #1;
    resetn[2] = 1'b0; req_valid[2] = 1'b0;
    @(posedge clk); #1;
    resetn[2] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    pulses = dok_cnt[2] - dok0;
    chk("midbusy_no_data_ok", 64'(pulses), 64'd0);
    run_ref(2, 64'h10, 3'd3, 8'hFF, 64'h0BAD_F00D_1234_5678, 1'b0, t);
    run_ref(2, 64'h10, 3'd3, 8'h00, 64'h0, 1'b0, t);

    // Randomised traffic across all three latencies against the reference memory
    for (int n = 0; n < 90; n++) begin
      int      k;
      addr_t   a;
      msize_t  sz;
      strobe_t st;
      word_t   d;
      k  = int'($urandom_range(0, NI - 1));
      sz = 3'($urandom_range(0, 3));
      a  = ({32'($urandom), 32'($urandom)} << 13) | 64'($urandom_range(0, 31) * 8)
           | 64'($urandom_range(0, 7));
      st = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      d  = {32'($urandom), 32'($urandom)};
      run_ref(k, a, sz, st, d, 1'b0, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
